// File: rtl/spi_mux_multi.sv
// SPI mode-0 slave that demultiplexes a header-addressed serial stream into CHANNELS
// parallel words, with an enable-mask load for the output drivers. Fully clk-synchronous.
`timescale 1ns/1ps
module spi_mux_multi #(
  parameter int CHANNELS    = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_nCS,
  input  logic                         spi_sck,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic [CHANNELS*DATA_W-1:0]   out,
  output logic [CHANNELS-1:0]          out_valid,
  output logic [CHANNELS-1:0]          out_en,
  output logic                         buffer_oe,
  output logic [2:0]                   status
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int EN_N  = (CHANNELS < 6) ? CHANNELS : 6;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]  CH_MAX    = CH_W'(CHANNELS - 1);
  localparam logic [7:0]       CH_LIM    = 8'(CHANNELS);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] MASK    = 3'd3;
  localparam logic [2:0] DISCARD = 3'd4;

  logic [SYNC_STAGES-1:0]       ncsSync_q, sckSync_q, mosiSync_q;
  logic                         sckPrev_q;
  logic [2:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]            shift_q, shift_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [CHANNELS*DATA_W-1:0]   out_q, out_d;
  logic [CHANNELS-1:0]          valid_q, valid_d;
  logic [CHANNELS-1:0]          en_q, en_d;
  logic                         err_q, err_d;
  logic                         frame_q, frame_d;
  logic                         resetActive_q;
  logic                         bufferOe_q;
  logic [7:0]                   misoShift_q, misoShift_d;

  logic              ncsS, sckS, mosiS, sckRise, sckFall;
  logic [DATA_W-1:0] word;
  logic [7:0]        statusByte;

  assign ncsS       = ncsSync_q[SYNC_STAGES-1];
  assign sckS       = sckSync_q[SYNC_STAGES-1];
  assign mosiS      = mosiSync_q[SYNC_STAGES-1];
  assign sckRise    = sckS & ~sckPrev_q;
  assign sckFall    = ~sckS & sckPrev_q;
  assign word       = {shift_q[DATA_W-2:0], mosiS};
  assign statusByte = {err_q, 1'b0, 6'(en_q[EN_N-1:0])};

  // Next-state logic; a rising nCS overrides any SCK activity in the same clk
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ch_d        = ch_q;
    out_d       = out_q;
    valid_d     = '0;
    en_d        = en_q;
    err_d       = err_q;
    frame_d     = frame_q;
    misoShift_d = misoShift_q;
    if (state_q != IDLE && ncsS) begin
      state_d = IDLE;
      frame_d = 1'b0;
      if (cnt_q != '0) err_d = 1'b1;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ncsS) begin
            state_d     = HEADER;
            cnt_d       = '0;
            shift_d     = '0;
            frame_d     = 1'b1;
            misoShift_d = statusByte;
          end
        end
        HEADER: begin
          if (sckFall) misoShift_d = {misoShift_q[6:0], 1'b0};
          if (sckRise) begin
            shift_d = word;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == HDR_LAST) begin
              cnt_d   = '0;
              shift_d = '0;
              if (word[7]) begin
                state_d = MASK;
              end else if ({1'b0, word[6:0]} < CH_LIM) begin
                state_d = DATA;
                ch_d    = word[CH_W-1:0];
                err_d   = 1'b0;
              end else begin
                state_d = DISCARD;
                err_d   = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (sckRise) begin
            shift_d = word;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == WORD_LAST) begin
              cnt_d   = '0;
              shift_d = '0;
              out_d[ch_q*DATA_W +: DATA_W] = word;
              valid_d[ch_q] = 1'b1;
              ch_d = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
            end
          end
        end
        MASK: begin
          if (sckRise) begin
            shift_d = word;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == WORD_LAST) begin
              cnt_d   = '0;
              shift_d = '0;
              en_d    = word[CHANNELS-1:0];
              err_d   = 1'b0;
              state_d = DISCARD;
            end
          end
        end
        DISCARD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ncsSync_q     <= '1;
      sckSync_q     <= '0;
      mosiSync_q    <= '0;
      sckPrev_q     <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      ch_q          <= '0;
      out_q         <= '0;
      valid_q       <= '0;
      en_q          <= '0;
      err_q         <= 1'b0;
      frame_q       <= 1'b0;
      resetActive_q <= 1'b1;
      bufferOe_q    <= 1'b0;
      misoShift_q   <= '0;
    end else begin
      ncsSync_q     <= {ncsSync_q[SYNC_STAGES-2:0], spi_nCS};
      sckSync_q     <= {sckSync_q[SYNC_STAGES-2:0], spi_sck};
      mosiSync_q    <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi};
      sckPrev_q     <= sckS;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      ch_q          <= ch_d;
      out_q         <= out_d;
      valid_q       <= valid_d;
      en_q          <= en_d;
      err_q         <= err_d;
      frame_q       <= frame_d;
      resetActive_q <= 1'b0;
      bufferOe_q    <= 1'b1;
      misoShift_q   <= misoShift_d;
    end
  end

  // MISO is only driven while the header is being clocked in
  assign spi_miso  = (state_q == HEADER) & misoShift_q[7];
  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_en    = en_q;
  assign buffer_oe = bufferOe_q;
  assign status    = {err_q, frame_q, resetActive_q};

endmodule

// File: tb/tb_spi_mux_multi.sv
// Directed self-checking bench for spi_mux_multi (CHANNELS=4, DATA_W=8).
// SPI is bit-banged with an SCK half-period of 8 system clocks.
`timescale 1ns/1ps
module tb_spi_mux_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_nCS;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] out;
  logic [3:0]  out_valid;
  logic [3:0]  out_en;
  logic        buffer_oe;
  logic [2:0]  status;

  int testsRun = 0;
  int testsFailed = 0;
  int validCount[4] = '{0, 0, 0, 0};
  int multiHot = 0;
  logic [7:0] misoByte;

  spi_mux_multi #(.CHANNELS(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_nCS(spi_nCS), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .out(out), .out_valid(out_valid),
    .out_en(out_en), .buffer_oe(buffer_oe), .status(status)
  );

  always #10 clk = ~clk;

  // Counts out_valid pulse-clks per channel and any multi-hot clk
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int c = 0; c < 4; c++) if (out_valid[c] === 1'b1) validCount[c]++;
      if ($countones(out_valid) > 1) multiHot++;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] validPack();
    return {8'(validCount[3]), 8'(validCount[2]), 8'(validCount[1]), 8'(validCount[0])};
  endfunction

  // Sends the n MSB-first bits of b; miso is sampled just before each SCK rise
  task automatic applyStimulus(input logic [7:0] b, input int n, output logic [7:0] miso);
    miso = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      waitClk(8);
      miso[i] = spi_miso;
      spi_sck = 1'b1;
      waitClk(8);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frameStart();
    spi_nCS = 1'b0;
    waitClk(8);
  endtask

  task automatic frameEnd();
    waitClk(8);
    spi_nCS = 1'b1;
    waitClk(10);
  endtask

  initial begin
    reset = 1'b0; spi_nCS = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    waitClk(3);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_status", status, 3'b001);
    checkOutput("reset_oe", buffer_oe, 0);
    checkOutput("reset_en_miso", {out_en, spi_miso}, 0);
    reset = 1'b1;
    waitClk(1);
    checkOutput("release_oe", buffer_oe, 1);
    checkOutput("release_status", status, 3'b000);

    // Write ch2 then auto-increment into ch3
    frameStart();
    checkOutput("frame_active", status, 3'b010);
    applyStimulus(8'h02, 8, misoByte);
    checkOutput("miso_hdr_1", misoByte, 8'h00);
    applyStimulus(8'hA5, 8, misoByte);
    checkOutput("miso_data_zero", misoByte, 8'h00);
    applyStimulus(8'h3C, 8, misoByte);
    frameEnd();
    checkOutput("t2_out", out, 32'h3CA5_0000);
    checkOutput("t2_valid", validPack(), 32'h0101_0000);
    checkOutput("t2_status", status, 3'b000);

    // Start at ch3, wrap to ch0
    frameStart();
    applyStimulus(8'h03, 8, misoByte);
    applyStimulus(8'h11, 8, misoByte);
    applyStimulus(8'h22, 8, misoByte);
    frameEnd();
    checkOutput("t3_out", out, 32'h11A5_0022);
    checkOutput("t3_valid", validPack(), 32'h0201_0001);

    // Mask load, trailing byte ignored
    frameStart();
    applyStimulus(8'h80, 8, misoByte);
    checkOutput("miso_hdr_mask", misoByte, 8'h00);
    applyStimulus(8'h0B, 8, misoByte);
    applyStimulus(8'hFF, 8, misoByte);
    frameEnd();
    checkOutput("t4_en", out_en, 4'b1011);
    checkOutput("t4_out", out, 32'h11A5_0022);
    checkOutput("t4_valid", validPack(), 32'h0201_0001);

    // Out-of-range header sets the sticky error; a valid header clears it
    frameStart();
    applyStimulus(8'h05, 8, misoByte);
    checkOutput("miso_hdr_en", misoByte, 8'h0B);
    applyStimulus(8'h77, 8, misoByte);
    frameEnd();
    checkOutput("t5_err", status, 3'b100);
    checkOutput("t5_out", out, 32'h11A5_0022);
    frameStart();
    applyStimulus(8'h01, 8, misoByte);
    checkOutput("miso_hdr_err", misoByte, 8'h8B);
    applyStimulus(8'h66, 8, misoByte);
    frameEnd();
    checkOutput("t5_clear", status, 3'b000);
    checkOutput("t5_out2", out, 32'h11A5_6622);
    checkOutput("t5_valid", validPack(), 32'h0201_0101);

    // nCS raised after 5 data bits
    frameStart();
    applyStimulus(8'h00, 8, misoByte);
    applyStimulus(8'hFF, 5, misoByte);
    frameEnd();
    checkOutput("t6_partial_out", out, 32'h11A5_6622);
    checkOutput("t6_partial_status", status, 3'b100);
    checkOutput("t6_partial_valid", validPack(), 32'h0201_0101);

    // Reset pulsed mid-word
    frameStart();
    applyStimulus(8'h02, 8, misoByte);
    applyStimulus(8'hF0, 4, misoByte);
    reset = 1'b0; spi_nCS = 1'b1; spi_sck = 1'b0;
    waitClk(3);
    reset = 1'b1;
    waitClk(10);
    checkOutput("t6_reset_out", out, 0);
    checkOutput("t6_reset_status", status, 3'b000);
    checkOutput("t6_reset_en", out_en, 0);
    checkOutput("t6_reset_valid", validPack(), 32'h0201_0101);

    // Recovery after reset
    frameStart();
    applyStimulus(8'h02, 8, misoByte);
    applyStimulus(8'h5A, 8, misoByte);
    frameEnd();
    checkOutput("t7_out", out, 32'h005A_0000);
    checkOutput("t7_valid", validPack(), 32'h0202_0101);
    checkOutput("valid_onehot", multiHot, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
